asteroid_mover: RTL and testbench

ASTEROID_MOVER -- requirements
Module: asteroid_mover

---
 rtl/asteroid_mover.sv | 103 ++++++++++
 tb/tb_asteroid_mover.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/asteroid_mover.sv
// Asteroid position generator: steps X/Y offsets once per TICK_DIV clocks with wraparound.
// Optional Y respawn from an LFSR on X wrap when ASTEROID_RANDOM_RESPAWN_EN is defined.
module asteroid_mover #(
  parameter int unsigned TICK_DIV  = 416667,
  parameter int unsigned XSTEP     = 1,
  parameter int unsigned YSTEP     = 1,
  parameter int unsigned XLIM      = 640,
  parameter int unsigned YLIM      = 480,
  parameter logic [9:0]  LFSR_SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic       asteroid_on,
  output logic [9:0] xmovaddr,
  output logic [9:0] ymovaddr,
  output logic       tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [10:0] XSTEP_W = 11'(XSTEP);
  localparam logic [10:0] YSTEP_W = 11'(YSTEP);
  localparam logic [10:0] XLIM_W  = 11'(XLIM);
  localparam logic [10:0] YLIM_W  = 11'(YLIM);

  logic          run_q, run_d;
  logic [CW-1:0] count_q, count_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [10:0]   x_sum, y_sum;
  logic          x_wrap, y_wrap;
  logic [9:0]    x_next, y_next;
  logic          at_max;

  assign x_sum  = {1'b0, x_q} + XSTEP_W;
  assign y_sum  = {1'b0, y_q} + YSTEP_W;
  assign x_wrap = (x_sum >= XLIM_W);
  assign y_wrap = (y_sum >= YLIM_W);
  assign x_next = x_wrap ? 10'(x_sum - XLIM_W) : x_sum[9:0];
  assign y_next = y_wrap ? 10'(y_sum - YLIM_W) : y_sum[9:0];
  assign at_max = (count_q == CNT_MAX);

`ifdef ASTEROID_RANDOM_RESPAWN_EN
  logic [9:0] lfsr_q, lfsr_d;
  logic [9:0] lfsr_r;
  logic [9:0] respawn_y;

  // x^10 + x^7 + 1 Fibonacci form; free-running so the respawn row is unpredictable
  assign lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  assign lfsr_r    = {1'b0, lfsr_q[8:0]};
  assign respawn_y = (lfsr_r >= YLIM_W[9:0]) ? (lfsr_r - YLIM_W[9:0]) : lfsr_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`endif

  // run_q delays the first count by one edge after reset release
  always_comb begin
    run_d   = 1'b1;
    count_d = count_q;
    x_d     = x_q;
    y_d     = y_q;
    if (!asteroid_on) begin
      count_d = '0;
      x_d     = '0;
      y_d     = '0;
    end else if (!halt && run_q) begin
      if (at_max) begin
        count_d = '0;
        x_d     = x_next;
`ifdef ASTEROID_RANDOM_RESPAWN_EN
        y_d     = x_wrap ? respawn_y : y_next;
`else
        y_d     = y_next;
`endif
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q   <= 1'b0;
      count_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      run_q   <= run_d;
      count_q <= count_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign tick     = at_max & ~halt & asteroid_on;
  assign xmovaddr = x_q;
  assign ymovaddr = y_q;

endmodule

// File: tb/tb_asteroid_mover.sv
// Self-checking bench for asteroid_mover: tick-count reference model plus directed pins and random phase.
module tb_asteroid_mover;

   localparam int TICK_DIV = 4;
   localparam int XSTEP    = 3;
   localparam int YSTEP    = 2;
   localparam int XLIM     = 640;
   localparam int YLIM     = 480;
   localparam logic [9:0] SEED = 10'h2A5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       halt = 1'b0;
   logic       asteroidOn = 1'b0;
   logic [9:0] xmovaddr;
   logic [9:0] ymovaddr;
   logic       tick;

   int checkCount = 0;
   int passCount = 0;

   // Reference state: X is derived from the number of completed ticks, not tracked per step
   logic       modelSynced = 1'b0;
   int         modelCnt = 0;
   int         modelTicks = 0;
   int         modelY = 0;
   logic [9:0] modelLfsr = SEED;

   asteroid_mover #(
      .TICK_DIV (TICK_DIV),
      .XSTEP    (XSTEP),
      .YSTEP    (YSTEP),
      .XLIM     (XLIM),
      .YLIM     (YLIM),
      .LFSR_SEED(SEED)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .halt       (halt),
      .asteroid_on(asteroidOn),
      .xmovaddr   (xmovaddr),
      .ymovaddr   (ymovaddr),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   function automatic int modelX();
      return (XSTEP * modelTicks) % XLIM;
   endfunction

   function automatic int nextY(int yNow, int xNow, logic [9:0] lfsrNow);
      int r;
      r = int'(lfsrNow[8:0]);
`ifdef ASTEROID_RANDOM_RESPAWN_EN
      if (xNow + XSTEP >= XLIM) return (r >= YLIM) ? r - YLIM : r;
`endif
      if (r < 0) return 0;
      return (yNow + YSTEP) % YLIM;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Advance the reference model on every active edge, mirroring the async clear
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         modelSynced <= 1'b0;
         modelCnt    <= 0;
         modelTicks  <= 0;
         modelY      <= 0;
         modelLfsr   <= SEED;
      end else begin
         modelLfsr   <= {modelLfsr[8:0], modelLfsr[9] ^ modelLfsr[6]};
         modelSynced <= 1'b1;
         if (!asteroidOn) begin
            modelCnt   <= 0;
            modelTicks <= 0;
            modelY     <= 0;
         end else if (!halt && modelSynced) begin
            if (modelCnt == TICK_DIV - 1) begin
               modelCnt   <= 0;
               modelTicks <= modelTicks + 1;
               modelY     <= nextY(modelY, modelX(), modelLfsr);
            end else begin
               modelCnt <= modelCnt + 1;
            end
         end
      end
   end

   // Mid-cycle comparison of every output against the model
   always @(negedge clk) begin
      checkOutput("model xmovaddr", int'(xmovaddr), modelX());
      checkOutput("model ymovaddr", int'(ymovaddr), modelY);
      checkOutput("model tick", int'(tick),
                  int'((modelCnt == TICK_DIV - 1) && !halt && asteroidOn));
      checkOutput("y bound", int'(ymovaddr < YLIM), 1);
   end

   task automatic pulseReset();
      reset = 1'b0;
      #1;
      checkOutput("async reset x", int'(xmovaddr), 0);
      checkOutput("async reset y", int'(ymovaddr), 0);
      #1;
      reset = 1'b1;
   endtask

   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         halt       = ($urandom_range(9) == 0);
         asteroidOn = ($urandom_range(999) != 0);
         if ($urandom_range(1499) == 0) pulseReset();
      end
   endtask

   initial begin
      int edges;
      reset      = 1'b0;
      halt       = 1'b0;
      asteroidOn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset x", int'(xmovaddr), 0);
      checkOutput("reset y", int'(ymovaddr), 0);
      checkOutput("reset tick", int'(tick), 0);
      #2;
      reset = 1'b1;

      for (int e = 1; e <= 9; e++) begin
         @(posedge clk);
         #1;
         if (e == 4 || e == 8) checkOutput("tick before update", int'(tick), 1);
         if (e == 5) checkOutput("first tick x", int'(xmovaddr), 3);
         if (e == 9) begin
            checkOutput("two ticks x", int'(xmovaddr), 6);
            checkOutput("two ticks y", int'(ymovaddr), 4);
         end
      end

      halt = 1'b1;
      for (int e = 0; e < 10; e++) begin
         @(posedge clk);
         #1;
         checkOutput("halt tick", int'(tick), 0);
      end
      checkOutput("halt hold x", int'(xmovaddr), 6);
      checkOutput("halt hold y", int'(ymovaddr), 4);
      halt = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("resume x", int'(xmovaddr), 9);
      checkOutput("resume y", int'(ymovaddr), 6);

      repeat (4 * 211) @(posedge clk);
      #1;
      checkOutput("x wrap", int'(xmovaddr), 2);
`ifndef ASTEROID_RANDOM_RESPAWN_EN
      checkOutput("y before wrap", int'(ymovaddr), 428);
`endif
      repeat (4 * 26) @(posedge clk);
      #1;
      checkOutput("x after 240 ticks", int'(xmovaddr), 80);
`ifndef ASTEROID_RANDOM_RESPAWN_EN
      checkOutput("y wrap", int'(ymovaddr), 0);
`endif

      asteroidOn = 1'b0;
      halt       = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("off x", int'(xmovaddr), 0);
      checkOutput("off y", int'(ymovaddr), 0);
      checkOutput("off tick", int'(tick), 0);
      asteroidOn = 1'b1;
      halt       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("restart tick", int'(tick), 1);
      @(posedge clk);
      #1;
      checkOutput("restart x", int'(xmovaddr), 3);
      checkOutput("restart y", int'(ymovaddr), 2);

      repeat (2) @(posedge clk);
      #1;
      pulseReset();
      edges = 0;
      while (xmovaddr == 10'd0 && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      checkOutput("first tick after reset", edges, TICK_DIV + 1);

      applyStimulus(3000);

      halt = 1'b0;
      asteroidOn = 1'b1;
      @(posedge clk);
      #1;
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
